// File: rtl/track_canvas.sv
// track_canvas: writer side of the handwriting path.
// Accumulates pen samples into a W x H ink bitmap and runs the start/finish
// handshake with the recogniser, latching its result digit.
module track_canvas #(
    parameter int W       = 52,
    parameter int H       = 52,
    parameter int BRUSH   = 1,
    parameter int TIMEOUT = 100000,
    parameter int AUTOCLR = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pen_valid,
    input  logic             i_pen_down,
    input  logic [5:0]       i_pen_x,
    input  logic [5:0]       i_pen_y,
    input  logic             i_submit,
    input  logic             i_clear,
    input  logic             i_finish,
    input  logic [3:0]       i_predicted_number,
    output logic [W*H-1:0]   o_track_input,
    output logic             o_start,
    output logic             o_busy,
    output logic             o_empty,
    output logic [3:0]       o_digit,
    output logic             o_digit_valid,
    output logic             o_timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        SIDLE  = 2'd0,
        SSTART = 2'd1,
        SWAIT  = 2'd2,
        SDONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [W*H-1:0]   r_bmp;
    logic [W*H-1:0]   w_bmp_next;
    logic [W*H-1:0]   w_mask;
    logic [W-1:0]     w_col_hit;
    logic [H-1:0]     w_row_hit;
    logic             w_in_range;
    logic             w_pen_write;
    logic             w_submit_edge;
    logic             w_fin_ok;
    logic             w_timeout;
    logic             r_submit_d;
    logic             r_empty;
    logic             r_start;
    logic             r_busy;
    logic [3:0]       r_digit;
    logic             r_digit_valid;
    logic             r_timeout_err;
    logic [CW-1:0]    r_cnt;

    // Brush footprint as separable column/row decodes; pixels beyond the
    // canvas edge simply have no decode line, which gives clipping for free.
    genvar gi, gj;
    generate
        for (gi = 0; gi < W; gi++) begin : g_col
            assign w_col_hit[gi] = (({2'b00, i_pen_x} + 8'(BRUSH)) >= 8'(gi)) &&
                                   ({2'b00, i_pen_x} <= (8'(gi) + 8'(BRUSH)));
        end
        for (gi = 0; gi < H; gi++) begin : g_row
            assign w_row_hit[gi] = (({2'b00, i_pen_y} + 8'(BRUSH)) >= 8'(gi)) &&
                                   ({2'b00, i_pen_y} <= (8'(gi) + 8'(BRUSH)));
        end
        for (gi = 0; gi < H; gi++) begin : g_mask_y
            for (gj = 0; gj < W; gj++) begin : g_mask_x
                assign w_mask[gi*W + gj] = w_row_hit[gi] & w_col_hit[gj];
            end
        end
    endgenerate

    // An off-canvas sample is dropped whole, not drawn as a clipped brush.
    assign w_in_range    = ({1'b0, i_pen_x} < 7'(W)) && ({1'b0, i_pen_y} < 7'(H));
    assign w_pen_write   = (r_state == SIDLE) && i_pen_valid && i_pen_down &&
                           w_in_range && !i_clear;
    assign w_submit_edge = i_submit && !r_submit_d;

    // Next bitmap: clear beats ink; the bitmap only moves while idle or on auto-clear.
    always_comb begin
        w_bmp_next = r_bmp;
        if (r_state == SIDLE && i_clear) begin
            w_bmp_next = '0;
        end else if (r_state == SDONE && AUTOCLR != 0) begin
            w_bmp_next = '0;
        end else if (w_pen_write) begin
            w_bmp_next = r_bmp | w_mask;
        end
    end

    // Handshake next-state logic and done-cycle qualifiers.
    always_comb begin
        w_state_next = r_state;
        w_fin_ok     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            SIDLE: begin
                if (w_submit_edge && !r_empty && !i_clear) begin
                    w_state_next = SSTART;
                end
            end
            SSTART: w_state_next = SWAIT;
            SWAIT: begin
                if (i_finish) begin
                    w_state_next = SDONE;
                    w_fin_ok     = 1'b1;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state_next = SDONE;
                    w_timeout    = 1'b1;
                end
            end
            default: w_state_next = SIDLE;
        endcase
    end

    // State, bitmap, status and result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= SIDLE;
            r_bmp         <= '0;
            r_empty       <= 1'b1;
            r_submit_d    <= 1'b0;
            r_start       <= 1'b0;
            r_busy        <= 1'b0;
            r_digit       <= 4'd0;
            r_digit_valid <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_next;
            r_bmp         <= w_bmp_next;
            r_empty       <= ~|w_bmp_next;
            r_submit_d    <= i_submit;
            r_start       <= (w_state_next == SSTART);
            r_busy        <= (w_state_next != SIDLE);
            r_digit_valid <= w_fin_ok;
            r_timeout_err <= w_timeout;
            if (w_fin_ok) begin
                r_digit <= i_predicted_number;
            end
            if (r_state == SWAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_track_input = r_bmp;
    assign o_start       = r_start;
    assign o_busy        = r_busy;
    assign o_empty       = r_empty;
    assign o_digit       = r_digit;
    assign o_digit_valid = r_digit_valid;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_track_canvas.sv
// tb_track_canvas: randomized bench for track_canvas against a pixel-level
// model of the canvas and a transaction-level model of the recogniser handshake.
module tb_track_canvas;

    localparam int W       = 52;
    localparam int H       = 52;
    localparam int NP      = W * H;
    localparam int BRUSH   = 1;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            pen_valid, pen_down, submit, clear, finish;
    logic [5:0]      pen_x, pen_y;
    logic [3:0]      predicted_number;
    logic [NP-1:0]   track_input;
    logic            start, busy, empty, digit_valid, timeout_err;
    logic [3:0]      digit;

    bit [NP-1:0]     model_bmp;
    int              model_digit;
    int              n_checks = 0;
    int              n_pass   = 0;

    track_canvas #(
        .W(W), .H(H), .BRUSH(BRUSH), .TIMEOUT(TIMEOUT), .AUTOCLR(1)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_pen_valid(pen_valid), .i_pen_down(pen_down),
        .i_pen_x(pen_x), .i_pen_y(pen_y),
        .i_submit(submit), .i_clear(clear),
        .i_finish(finish), .i_predicted_number(predicted_number),
        .o_track_input(track_input), .o_start(start), .o_busy(busy),
        .o_empty(empty), .o_digit(digit), .o_digit_valid(digit_valid),
        .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish before 90000 cycles");
        $fatal(1);
    end

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pen_valid = 0; pen_down = 0; pen_x = 0; pen_y = 0;
        submit = 0; clear = 0; finish = 0; predicted_number = 0;
    endtask

    function automatic int bmp_diff();
        return $countones(track_input ^ model_bmp);
    endfunction

    // Ink the brush square around (x,y), keeping only on-canvas pixels.
    function automatic void model_paint(input int x, input int y);
        if (x < W && y < H) begin
            for (int dy = -BRUSH; dy <= BRUSH; dy++)
                for (int dx = -BRUSH; dx <= BRUSH; dx++)
                    if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
                        model_bmp[(y + dy) * W + (x + dx)] = 1'b1;
        end
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_bmp"}, bmp_diff(), 0);
        chk({tag, "_empty"}, empty, (model_bmp == '0));
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_dv"}, digit_valid, 0);
        chk({tag, "_te"}, timeout_err, 0);
        chk({tag, "_digit"}, digit, model_digit);
    endtask

    task automatic pen_cycle(input int x, input int y, input bit dn, input bit vld,
                             input bit clr, input bit fin);
        pen_x = 6'(x); pen_y = 6'(y); pen_down = dn; pen_valid = vld;
        clear = clr; finish = fin; predicted_number = 4'($urandom);
        step();
        idle_inputs();
        if (clr) model_bmp = '0;
        else if (vld && dn) model_paint(x, y);
        $display("pen x=%0d y=%0d dn=%0d vld=%0d clr=%0d fin=%0d ink=%0d", x, y, dn, vld, clr, fin,
                 $countones(model_bmp));
        check_idle("pen");
    endtask

    task automatic submit_ignored(input bit clr);
        submit = 1; clear = clr;
        step();
        idle_inputs();
        if (clr) model_bmp = '0;
        $display("submit ignored clr=%0d", clr);
        check_idle("noSub");
        step();
        check_idle("noSub2");
    endtask

    // One full submit transaction; delay >= TIMEOUT means the recogniser never answers.
    task automatic handshake(input int delay, input logic [3:0] pn, input bit freeze,
                             input bit pen_with);
        int  px, py;
        bit  timed_out;
        px = $urandom_range(0, W - 1);
        py = $urandom_range(0, H - 1);
        if (pen_with) begin
            pen_valid = 1; pen_down = 1; pen_x = 6'(px); pen_y = 6'(py);
        end
        submit = 1;
        step();
        idle_inputs();
        if (pen_with) model_paint(px, py);
        chk("hs_start", start, 1);
        chk("hs_busy", busy, 1);
        chk("hs_bmp", bmp_diff(), 0);
        step();
        chk("hs_pulse", start, 0);
        for (int k = 0; k < TIMEOUT; k++) begin
            if (freeze) begin
                pen_valid = 1; pen_down = 1;
                pen_x = 6'($urandom_range(0, W - 1)); pen_y = 6'($urandom_range(0, H - 1));
                clear = 1'($urandom); submit = 1'($urandom);
            end
            finish = (k == delay);
            predicted_number = (k == delay) ? pn : 4'($urandom);
            step();
            idle_inputs();
            if (k == delay || k == TIMEOUT - 1) break;
            chk("wait_start", start, 0);
            chk("wait_busy", busy, 1);
            chk("wait_bmp", bmp_diff(), 0);
            chk("wait_dv", digit_valid, 0);
            chk("wait_te", timeout_err, 0);
        end
        timed_out = (delay >= TIMEOUT);
        if (!timed_out) model_digit = pn;
        $display("handshake delay=%0d pn=%0d freeze=%0d pen_with=%0d timeout=%0d", delay, pn,
                 freeze, pen_with, timed_out);
        chk("done_dv", digit_valid, !timed_out);
        chk("done_te", timeout_err, timed_out);
        chk("done_digit", digit, model_digit);
        chk("done_busy", busy, 1);
        chk("done_start", start, 0);
        chk("done_bmp", bmp_diff(), 0);
        step();
        model_bmp = '0;
        check_idle("after");
    endtask

    initial begin
        int r;
        idle_inputs();
        model_bmp   = '0;
        model_digit = 0;

        // reset
        rst = 1;
        step();
        step();
        $display("reset");
        check_idle("rst");
        rst = 0;

        // drawing at the corners with clipping
        pen_cycle(0, 0, 1, 1, 0, 0);
        pen_cycle(51, 51, 1, 1, 0, 0);
        chk("bit0", track_input[0], 1);
        chk("bit53", track_input[53], 1);
        chk("bit2650", track_input[2650], 1);
        chk("bit2703", track_input[2703], 1);
        chk("ink8", $countones(track_input), 8);
        pen_cycle(52, 10, 1, 1, 0, 0);
        chk("ink_off", $countones(track_input), 8);

        // handshake with answer, then a timeout that keeps the old digit
        handshake(9, 4'd7, 0, 0);
        pen_cycle(20, 30, 1, 1, 0, 0);
        handshake(40, 4'd3, 0, 0);
        chk("to_digit", digit, 7);

        // freeze during wait, and pen committed together with submit
        pen_cycle(10, 5, 1, 1, 0, 0);
        handshake(5, 4'd2, 1, 1);

        // edge cases
        submit_ignored(0);
        pen_cycle(7, 7, 1, 1, 0, 0);
        pen_cycle(30, 8, 1, 1, 1, 0);
        pen_cycle(12, 40, 1, 1, 0, 1);
        submit_ignored(1);

        // reset in the middle of a wait
        pen_cycle(25, 25, 1, 1, 0, 0);
        submit = 1;
        step();
        idle_inputs();
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        model_bmp   = '0;
        model_digit = 0;
        $display("reset during wait");
        check_idle("rstWait");

        // randomized mix
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 70)
                pen_cycle($urandom_range(0, 55), $urandom_range(0, 55), ($urandom % 4) != 0,
                          ($urandom % 8) != 0, 0, ($urandom % 10) == 0);
            else if (r < 75)
                pen_cycle($urandom_range(0, 51), $urandom_range(0, 51), 1, 1, 1, 0);
            else if (model_bmp != '0)
                handshake($urandom_range(0, 20), 4'($urandom), 1'($urandom), 1'($urandom));
            else
                submit_ignored(1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
